// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding, operating-mode constants and a counter sizing helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Ceiling log2, used to size the bit counter (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_addsub_ctrl_fa_cell.sv
// One-bit full adder cell time-shared by the serial controller.
// Built from two half adders; the two partial carries are ORed together.

module serial_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);
  logic p_s;
  logic g_lo_s;
  logic g_hi_s;

  serial_ha u_ha_lo (
    .x (x),
    .y (y),
    .s (p_s),
    .c (g_lo_s)
  );

  serial_ha u_ha_hi (
    .x (p_s),
    .y (cin),
    .s (s),
    .c (g_hi_s)
  );

  assign co = g_lo_s | g_hi_s;
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller. A single full adder cell is stepped
// across the operands LSB first, one bit per clock. Subtraction is done as
// a + ~b + 1 by inverting b at load time and seeding the carry with 1.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;
  logic             last_bit_s;
  logic             c_msb_in_s;
  logic [WIDTH-1:0] rs_shift_s;

  serial_fa_cell u_fa (
    .x   (ra_q[0]),
    .y   (rb_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  assign last_bit_s = (cnt_q == CNT_LAST);
  // On the last RUN cycle the carry flop still holds the carry into the MSB.
  assign c_msb_in_s = carry_q;
  assign rs_shift_s = {fa_s, rs_q[WIDTH-1:1]};

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          ra_d    = a;
          rb_d    = (sub == MODE_SUB) ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        rs_d    = rs_shift_s;
        ra_d    = {1'b0, ra_q[WIDTH-1:1]};
        rb_d    = {1'b0, rb_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit_s) begin
          state_d = ST_FIN;
          sum_d   = rs_shift_s;
          cout_d  = fa_co;
          ovf_d   = c_msb_in_s ^ fa_co;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_FIN);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift registers, carry, bit counter and result/handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH = 8). Expected results
// come from plain integer arithmetic on the operands.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests;
  int fails;

  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: {ovf, cout, sum} from unsigned/signed integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    int ua, ub, sa, sb, ures, sres;
    logic [W-1:0] rsum;
    logic rc, rv;
    ua = int'(ta);
    ub = int'(tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (ts) begin
      ures = ua - ub;
      sres = sa - sb;
      rc   = (ua >= ub);
    end else begin
      ures = ua + ub;
      sres = sa + sb;
      rc   = (ures > 255);
    end
    rsum = W'(ures & 255);
    rv   = (sres > 127) || (sres < -128);
    return {rv, rc, rsum};
  endfunction

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input string tag);
    logic [W+1:0] exp;
    int edges;
    int busy_cycles;
    exp = model(ta, tb, ts);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; sub = ts;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    check($sformatf("%s busy_on", tag), 32'(busy), 32'(1));
    check($sformatf("%s sum_held", tag), 32'(sum), 32'(last_sum));
    edges = 1;
    busy_cycles = 1;
    while (!done && edges < W + 10) begin
      @(negedge clk);
      edges++;
      if (busy) busy_cycles++;
    end
    check($sformatf("%s latency", tag), 32'(edges), 32'(W + 1));
    check($sformatf("%s busy_cycles", tag), 32'(busy_cycles), 32'(W));
    check($sformatf("%s done_busy", tag), 32'({done, busy}), 32'(2'b10));
    check($sformatf("%s sum", tag), 32'(sum), 32'(exp[W-1:0]));
    check($sformatf("%s cout", tag), 32'(cout), 32'(exp[W]));
    check($sformatf("%s ovf", tag), 32'(ovf), 32'(exp[W+1]));
    last_sum  = exp[W-1:0];
    last_cout = exp[W];
    last_ovf  = exp[W+1];
    @(negedge clk);
    check($sformatf("%s done_drop", tag), 32'(done), 32'(0));
    check($sformatf("%s hold", tag), 32'({ovf, cout, sum}), 32'({last_ovf, last_cout, last_sum}));
  endtask

  initial begin
    int pulses;
    int last_edge;
    logic interval_ok;
    logic stable_ok;
    logic quiet_ok;
    tests = 0;
    fails = 0;
    last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({busy, done, ovf, cout, sum}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Plan 1-3: directed arithmetic and boundaries
    do_op(8'h25, 8'h1A, 1'b0, "add_basic");
    do_op(8'hFF, 8'h01, 1'b0, "add_wrap");
    do_op(8'h7F, 8'h01, 1'b0, "add_ovf");
    do_op(8'h10, 8'h20, 1'b1, "sub_borrow");
    do_op(8'h80, 8'h01, 1'b1, "sub_ovf");
    do_op(8'h5A, 8'h00, 1'b1, "sub_zero");
    check("sub_zero_literal", 32'({ovf, cout, sum}), 32'({1'b0, 1'b1, 8'h5A}));

    // Randomised operations
    for (int i = 0; i < 16; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    // Plan 4: start pulses during RUN and FIN are ignored
    @(negedge clk);
    start = 1'b1; a = 8'h05; b = 8'h03; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("ignore_done", 32'(done), 32'(1));
    check("ignore_sum", 32'(sum), 32'(8'h08));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    quiet_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (busy || done) quiet_ok = 1'b0;
      @(negedge clk);
    end
    check("ignore_no_second_op", 32'(quiet_ok), 32'(1));
    check("ignore_sum_held", 32'(sum), 32'(8'h08));

    // Plan 5: reset mid-RUN aborts immediately
    start = 1'b1; a = 8'h25; b = 8'h1A; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({busy, done, ovf, cout, sum}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy || done) quiet_ok = 1'b0;
    end
    check("abort_no_done", 32'(quiet_ok), 32'(1));
    last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
    do_op(8'h01, 8'h01, 1'b0, "after_abort");

    // Plan 6: start held high, back-to-back operations every W+2 cycles
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h01; sub = 1'b0;
    pulses = 0;
    last_edge = -1;
    interval_ok = 1'b1;
    stable_ok = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      @(negedge clk);
      if (done) begin
        if (pulses > 0 && (e - last_edge) != W + 2) interval_ok = 1'b0;
        pulses++;
        last_edge = e;
        check($sformatf("hold_start_sum%0d", pulses), 32'({busy, sum}), 32'({1'b0, 8'h10}));
      end else if (pulses > 0 && (sum !== 8'h10 || cout !== 1'b0 || ovf !== 1'b0)) begin
        stable_ok = 1'b0;
      end
    end
    start = 1'b0;
    check("hold_start_pulses", 32'(pulses), 32'(4));
    check("hold_start_interval", 32'(interval_ok), 32'(1));
    check("hold_start_stable", 32'(stable_ok), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
